// File: rtl/ram_16b_24a.sv
// ram_16b_24a: word-addressed RAM behind a shared tri-state data bus.
// Reads are combinational. Writes commit on the rising clock edge.
// An asynchronous active-low reset makes every word read back as zero.
module ram_16b_24a #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_AWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic                  rwe,
  input  logic                  roe,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam int unsigned Depth = 2 ** MEM_AWIDTH;

  // Word index and range decode. Only unused upper address bits make an access out of range.
  logic [MEM_AWIDTH-1:0] idx;
  logic                  in_range;

  assign idx = addr[MEM_AWIDTH-1:0];

  if (MEM_AWIDTH < ADDR_WIDTH) begin : g_range
    assign in_range = (addr[ADDR_WIDTH-1:MEM_AWIDTH] == '0);
  end else begin : g_full
    assign in_range = 1'b1;
  end

  // The word array itself has no reset.
  // A per-word written flag is cleared asynchronously instead, and a word whose
  // flag is clear reads as zero. This matches a full clear without having to
  // reset the storage.
  logic [Depth-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  wr_en;

  // Writes are gated by reset, so an edge taken while r is low is discarded.
  assign wr_en = rwe & r & in_range;

  // Next-state of the written flags.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[idx] = 1'b1;
    end
  end

  // Written flags: cleared asynchronously while r is low.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Storage array: the bus value is captured on a qualified write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= data;
    end
  end

  // Read path. An unknown address propagates X through the selects in simulation.
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  drive;

  assign rd_word = valid_q[idx] ? mem_q[idx] : '0;
  assign rd_data = in_range ? rd_word : '0;

  // The data lines are driven only for a read outside reset.
  // A write always wins, so the block never drives against the bus master.
  assign drive = r & roe & ~rwe;
  assign data  = drive ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_16b_24a.sv
// Scoreboard bench for ram_16b_24a.
// The driver pushes expected bus values into a queue. The monitor pops each
// entry and compares it with the bus when the sample event fires.
// A pull-up on the bus shows a released bus as all ones.
// Driving zero from the bench at the same time exposes a block that drives
// the bus when it should not.
module tb_ram_16b_24a;

  localparam int unsigned Aw    = 24;
  localparam int unsigned Dw    = 16;
  localparam int unsigned Maw   = 16;
  localparam logic [23:0] Limit = 24'h010000;

  logic          clk = 1'b0;
  logic          r;
  logic          rwe;
  logic          roe;
  logic [Aw-1:0] addr;
  logic          tb_oe;
  logic [Dw-1:0] tb_val;
  wire  [Dw-1:0] data_w;

  assign data_w = tb_oe ? tb_val : {Dw{1'bz}};
  pullup (data_w);

  always #5 clk = ~clk;

  ram_16b_24a #(
    .ADDR_WIDTH(Aw),
    .DATA_WIDTH(Dw),
    .MEM_AWIDTH(Maw)
  ) u_dut (
    .clk (clk),
    .r   (r),
    .rwe (rwe),
    .roe (roe),
    .addr(addr),
    .data(data_w)
  );

  typedef struct {
    string       name;
    logic [23:0] a;
    logic [15:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  event        sample_ev;
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model: sparse word store. A missing entry means never written since reset.
  logic [15:0] model [int];

  function automatic logic [15:0] ref_read(input logic [23:0] a);
    if (a >= Limit) return 16'h0000;
    if (model.exists(int'(a))) return model[int'(a)];
    return 16'h0000;
  endfunction

  // Monitor: pops one expectation per sample event and compares it with the bus.
  initial begin
    forever begin
      @(sample_ev);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: sample with empty scoreboard, bus=%h", data_w);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_w !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s addr=%h got=%h want=%h", mon_e.name, mon_e.a, data_w, mon_e.exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic expect_now(input string name, input logic [15:0] e);
    exp_t x;
    x.name = name;
    x.a    = addr;
    x.exp  = e;
    exp_q.push_back(x);
    ->sample_ev;
    #1;
  endtask

  // Bus must be released: pull-up reads all ones, and a bench-driven zero stays zero.
  task automatic check_released(input string name);
    tb_oe = 1'b0;
    #1;
    expect_now({name, "_pu"}, 16'hFFFF);
    tb_val = 16'h0000;
    tb_oe  = 1'b1;
    #1;
    expect_now({name, "_drv0"}, 16'h0000);
    tb_oe = 1'b0;
  endtask

  task automatic do_write(input logic [23:0] a, input logic [15:0] d, input logic oe);
    @(negedge clk);
    addr   = a;
    rwe    = 1'b1;
    roe    = oe;
    tb_val = d;
    tb_oe  = 1'b1;
    @(posedge clk);
    if (r && a < Limit) model[int'(a)] = d;
    #1;
    rwe   = 1'b0;
    roe   = 1'b0;
    tb_oe = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [23:0] a);
    @(negedge clk);
    addr  = a;
    rwe   = 1'b0;
    tb_oe = 1'b0;
    roe   = 1'b1;
    #1;
    expect_now(name, ref_read(a));
    roe = 1'b0;
  endtask

  task automatic do_idle(input string name, input logic [23:0] a);
    @(negedge clk);
    addr = a;
    rwe  = 1'b0;
    roe  = 1'b0;
    check_released(name);
  endtask

  function automatic logic [23:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 24'($urandom_range(0, 63));
      1:       return 24'(32'h0000FFC0 + $urandom_range(0, 127));
      2:       return {8'($urandom_range(1, 255)), 16'($urandom_range(0, 63))};
      default: return 24'($urandom());
    endcase
  endfunction

  initial begin
    r      = 1'b0;
    rwe    = 1'b0;
    roe    = 1'b0;
    tb_oe  = 1'b0;
    tb_val = 16'h0000;
    addr   = '0;
    model.delete();

    // Reset, then read back zeros.
    repeat (2) @(posedge clk);
    @(negedge clk);
    addr = 24'h000010;
    roe  = 1'b1;
    check_released("rst_z");
    roe = 1'b0;
    @(negedge clk);
    r = 1'b1;
    do_read("rst_rd_10", 24'h000010);
    do_read("rst_rd_ffff", 24'h00FFFF);

    // Write then read back.
    do_write(24'h000020, 16'hBEEF, 1'b0);
    do_read("rb_20", 24'h000020);
    do_read("rb_21", 24'h000021);

    // Write wins over output enable, then idle releases the bus.
    do_write(24'h000030, 16'h1234, 1'b1);
    do_idle("idle_z", 24'h000030);
    do_read("prio_30", 24'h000030);

    // Address boundaries and no aliasing.
    do_write(24'h00FFFF, 16'hA5A5, 1'b0);
    do_read("bnd_ffff", 24'h00FFFF);
    do_write(24'h010000, 16'h5A5A, 1'b0);
    do_read("oor_10000", 24'h010000);
    do_read("alias_0", 24'h000000);

    // Asynchronous reset pulse between clock edges.
    do_write(24'h000040, 16'hCAFE, 1'b0);
    do_read("pre_40", 24'h000040);
    @(negedge clk);
    addr = 24'h000040;
    roe  = 1'b1;
    r    = 1'b0;
    model.delete();
    check_released("arst_z");
    r   = 1'b1;
    roe = 1'b0;
    do_read("arst_40", 24'h000040);
    do_read("arst_20", 24'h000020);

    // Write attempted across an edge while reset is held.
    @(negedge clk);
    r = 1'b0;
    do_write(24'h000050, 16'h1111, 1'b0);
    @(negedge clk);
    r = 1'b1;
    do_read("rstwr_50", 24'h000050);

    // Back-to-back writes, then a single overwrite.
    do_write(24'h000100, 16'h0001, 1'b0);
    do_write(24'h000101, 16'h0002, 1'b0);
    do_write(24'h000102, 16'h0003, 1'b0);
    do_read("b2b_100", 24'h000100);
    do_read("b2b_101", 24'h000101);
    do_read("b2b_102", 24'h000102);
    do_write(24'h000101, 16'hFFFF, 1'b0);
    do_read("ovw_100", 24'h000100);
    do_read("ovw_101", 24'h000101);
    do_read("ovw_102", 24'h000102);

    // Randomized mix of writes, reads and idles.
    for (int i = 0; i < 400; i++) begin
      logic [23:0] ra;
      int          op;
      ra = rand_addr();
      op = int'($urandom_range(0, 6));
      if (op <= 2) begin
        do_write(ra, 16'($urandom()), 1'($urandom_range(0, 1)));
      end else if (op <= 5) begin
        do_read("rand_rd", ra);
      end else begin
        do_idle("rand_idle", ra);
      end
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
